// File: rtl/instr_issuer_if.sv
// Selection, handshake and status bundle between the board-side issuer and the pipeline fetch input.
interface instr_issuer_if;
  logic [2:0]  sel_code;
  logic        sel_valid;
  logic        issue_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic [2:0]  alu_ctl;
  logic [7:0]  issued_count;
  logic        busy;

  modport master (
    input  sel_code, sel_valid, issue_ready,
    output instr, instr_valid, alu_ctl, issued_count, busy
  );

  modport slave (
    output sel_code, sel_valid, issue_ready,
    input  instr, instr_valid, alu_ctl, issued_count, busy
  );
endinterface

// File: rtl/instr_issuer.sv
// Debounces a 3-bit select code and issues one encoded MIPS instruction per stable selection.
// Optional auto-repeat of a held selection is enabled by defining ISSUER_AUTO_REPEAT_EN.
module instr_issuer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned RESET_PTR     = 8
`ifdef ISSUER_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_GAP    = 16
`endif
) (
  input logic            clk,
  input logic            rst_n,
  instr_issuer_if.master bus
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [4:0] PTR_INIT   = 5'(RESET_PTR);

`ifdef ISSUER_AUTO_REPEAT_EN
  localparam logic [15:0] GAP_LAST = 16'(REPEAT_GAP - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE, GAP} state_t;
  logic [15:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
`endif

  state_t     state, state_next;
  logic [2:0] code_q;
  logic [7:0] stable_cnt;
  logic [4:0] reg_ptr;
  logic       load, xfer;

  function automatic logic [31:0] encode(input logic [2:0] code, input logic [4:0] p);
    logic [4:0] rt, rd;
    logic [5:0] funct;
    rt = p + 5'd1;
    rd = p + 5'd2;
    case (code)
      3'd4:    funct = 6'b100010;
      3'd5:    funct = 6'b100100;
      3'd6:    funct = 6'b100101;
      3'd7:    funct = 6'b101010;
      default: funct = 6'b100000;
    endcase
    case (code)
      3'd0:    encode = {6'b100011, p, rt, 9'b0, p, 2'b00};
      3'd1:    encode = {6'b101011, p, rt, 9'b0, p, 2'b00};
      3'd2:    encode = {6'b000100, p, rt, 16'h0001};
      default: encode = {6'b000000, p, rt, rd, 5'b00000, funct};
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] code);
    case (code)
      3'd2, 3'd4: alu_of = 3'b110;
      3'd5:       alu_of = 3'b000;
      3'd6:       alu_of = 3'b001;
      3'd7:       alu_of = 3'b111;
      default:    alu_of = 3'b010;
    endcase
  endfunction

  always_comb begin
    state_next = state;
    load       = 1'b0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (stable_cnt == STABLE_MAX) begin
          state_next = ISSUE;
          load       = 1'b1;
        end
      end
      ISSUE: begin
        if (bus.instr_valid && bus.issue_ready) begin
          state_next = DONE;
          xfer       = 1'b1;
        end
      end
      DONE: begin
        // A zero count means the selection was dropped or changed since the issue.
        if (stable_cnt == 8'd0)
          state_next = IDLE;
`ifdef ISSUER_AUTO_REPEAT_EN
        else if (stable_cnt == STABLE_MAX)
          state_next = GAP;
`endif
      end
`ifdef ISSUER_AUTO_REPEAT_EN
      GAP: begin
        if (stable_cnt != STABLE_MAX)
          state_next = IDLE;
        else if (gap_cnt == GAP_LAST) begin
          state_next = ISSUE;
          load       = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      code_q           <= 3'd0;
      stable_cnt       <= 8'd0;
      reg_ptr          <= PTR_INIT;
      bus.instr        <= 32'd0;
      bus.instr_valid  <= 1'b0;
      bus.alu_ctl      <= 3'd0;
      bus.issued_count <= 8'd0;
      bus.busy         <= 1'b0;
`ifdef ISSUER_AUTO_REPEAT_EN
      gap_cnt          <= 16'd0;
`endif
    end else begin
      state <= state_next;
      if (!bus.sel_valid || bus.sel_code != code_q) begin
        code_q     <= bus.sel_code;
        stable_cnt <= 8'd0;
      end else if (stable_cnt != STABLE_MAX) begin
        stable_cnt <= stable_cnt + 8'd1;
      end
      if (load) begin
        bus.instr       <= encode(code_q, reg_ptr);
        bus.alu_ctl     <= alu_of(code_q);
        bus.instr_valid <= 1'b1;
      end
      if (xfer) begin
        bus.instr_valid  <= 1'b0;
        bus.issued_count <= bus.issued_count + 8'd1;
        reg_ptr          <= reg_ptr + 5'd1;
      end
      bus.busy <= (state_next == ISSUE) || (state_next == DONE);
`ifdef ISSUER_AUTO_REPEAT_EN
      if (state == GAP && state_next == GAP)
        gap_cnt <= gap_cnt + 16'd1;
      else
        gap_cnt <= 16'd0;
`endif
    end
  end

endmodule
